// File: rtl/microwave_controller.sv
// Microwave oven controller.
// Collects up to three keypad digits into an external count-down timer,
// runs the magnetron while the door is closed and time remains, supports
// pause/resume and stop/clear, and beeps for BEEP_CYCLES once the timer
// reaches 0:00.
//
// Parameters:
//   TICK_DIV    - clk cycles per one-second count strobe (>= 2)
//   BEEP_CYCLES - done-beep duration in clk cycles (>= 1)
// Ports:
//   clk          - system clock, all state updates on rising edge
//   clr          - synchronous active-high reset
//   key_valid    - one-cycle keypad strobe
//   key_data     - keypad digit, valid with key_valid
//   start        - start/resume button level
//   stop_clear   - stop/clear button level
//   door_closed  - 1 = door closed
//   timer_zero   - timer reports 0:00
//   timer_clrn   - active-low clear to timer
//   timer_loadn  - active-low digit load to timer
//   timer_data   - digit presented to timer
//   timer_enable - one-cycle count-down strobe to timer
//   mag_on       - magnetron drive
//   beep         - done indicator
//   state        - IDLE=0, ENTRY=1, COOKING=2, PAUSED=3, DONE=4
module microwave_controller #(
  parameter int unsigned TICK_DIV    = 100,
  parameter int unsigned BEEP_CYCLES = 300
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_data,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic       timer_clrn,
  output logic       timer_loadn,
  output logic [3:0] timer_data,
  output logic       timer_enable,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    COOKING = 3'd2,
    PAUSED  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned BW = $clog2(BEEP_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BEEP_MAX  = BW'(BEEP_CYCLES - 1);

  state_t        cur_state;
  logic [1:0]    digit_cnt;
  logic [PW-1:0] presc;
  logic [BW-1:0] beep_cnt;
  logic          key_ok;

  assign key_ok = key_valid && (key_data <= 4'd9) && (digit_cnt != 2'd3);
  assign state  = cur_state;

  always_ff @(posedge clk) begin
    if (clr) begin
      cur_state    <= IDLE;
      digit_cnt    <= '0;
      presc        <= '0;
      beep_cnt     <= '0;
      timer_clrn   <= 1'b0;
      timer_loadn  <= 1'b1;
      timer_data   <= '0;
      timer_enable <= 1'b0;
      mag_on       <= 1'b0;
      beep         <= 1'b0;
    end else begin
      // Every output is a one-cycle pulse or level re-asserted by its state,
      // so defaults here give the idle values for any cycle not overridden.
      timer_clrn   <= 1'b1;
      timer_loadn  <= 1'b1;
      timer_data   <= '0;
      timer_enable <= 1'b0;
      mag_on       <= 1'b0;
      beep         <= 1'b0;

      case (cur_state)
        IDLE: begin
          if (!stop_clear && key_ok) begin
            timer_loadn <= 1'b0;
            timer_data  <= key_data;
            digit_cnt   <= digit_cnt + 2'd1;
            cur_state   <= ENTRY;
          end
        end

        ENTRY: begin
          if (stop_clear) begin
            timer_clrn <= 1'b0;
            digit_cnt  <= '0;
            cur_state  <= IDLE;
          end else if (start && door_closed && !timer_zero) begin
            presc     <= '0;
            mag_on    <= 1'b1;
            cur_state <= COOKING;
          end else if (key_ok) begin
            timer_loadn <= 1'b0;
            timer_data  <= key_data;
            digit_cnt   <= digit_cnt + 2'd1;
          end
        end

        COOKING: begin
          if (stop_clear || !door_closed) begin
            cur_state <= PAUSED;
          end else if (timer_zero) begin
            beep      <= 1'b1;
            beep_cnt  <= '0;
            cur_state <= DONE;
          end else begin
            mag_on <= 1'b1;
            if (presc == PRESC_MAX) begin
              presc        <= '0;
              timer_enable <= 1'b1;
            end else begin
              presc <= presc + 1'b1;
            end
          end
        end

        PAUSED: begin
          // Prescaler is left untouched so a resume continues the current second.
          if (stop_clear) begin
            timer_clrn <= 1'b0;
            digit_cnt  <= '0;
            presc      <= '0;
            cur_state  <= IDLE;
          end else if (start && door_closed) begin
            mag_on    <= 1'b1;
            cur_state <= COOKING;
          end
        end

        DONE: begin
          if (stop_clear || key_valid || (beep_cnt == BEEP_MAX)) begin
            digit_cnt <= '0;
            cur_state <= IDLE;
          end else begin
            beep     <= 1'b1;
            beep_cnt <= beep_cnt + 1'b1;
          end
        end

        default: cur_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_controller.sv
// Directed testbench for microwave_controller (TICK_DIV=4, BEEP_CYCLES=5).
module tb_microwave_controller;

  logic       clk = 1'b0;
  logic       clr;
  logic       key_valid;
  logic [3:0] key_data;
  logic       start;
  logic       stop_clear;
  logic       door_closed;
  logic       timer_zero;
  logic       timer_clrn;
  logic       timer_loadn;
  logic [3:0] timer_data;
  logic       timer_enable;
  logic       mag_on;
  logic       beep;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;
  logic door_s;

  microwave_controller #(
    .TICK_DIV   (4),
    .BEEP_CYCLES(5)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .key_valid   (key_valid),
    .key_data    (key_data),
    .start       (start),
    .stop_clear  (stop_clear),
    .door_closed (door_closed),
    .timer_zero  (timer_zero),
    .timer_clrn  (timer_clrn),
    .timer_loadn (timer_loadn),
    .timer_data  (timer_data),
    .timer_enable(timer_enable),
    .mag_on      (mag_on),
    .beep        (beep),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_key(input logic [3:0] d);
    key_valid = 1'b1;
    key_data  = d;
    tick();
    key_valid = 1'b0;
    key_data  = 4'd0;
  endtask

  // Door level the DUT sampled at each edge, for the magnetron interlock check.
  always @(posedge clk) door_s <= door_closed;

  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      assert (!(mag_on && !door_s)) else begin
        bad++;
        $error("FAIL mag_interlock: observed mag_on=%0b door=%0b", mag_on, door_s);
      end
      total++;
      assert ((32'(!timer_loadn) + 32'(!timer_clrn) + 32'(timer_enable)) <= 1) else begin
        bad++;
        $error("FAIL pulse_excl: observed loadn=%0b clrn=%0b en=%0b required at most one",
               timer_loadn, timer_clrn, timer_enable);
      end
    end
  end

  initial begin
    clr = 1'b1; key_valid = 1'b0; key_data = 4'd0; start = 1'b0;
    stop_clear = 1'b0; door_closed = 1'b1; timer_zero = 1'b0;

    // Reset
    tick();
    check("rst_state", state, 0);
    check("rst_clrn", timer_clrn, 0);
    check("rst_loadn", timer_loadn, 1);
    check("rst_data", timer_data, 0);
    check("rst_en", timer_enable, 0);
    check("rst_mag", mag_on, 0);
    check("rst_beep", beep, 0);
    clr = 1'b0;
    tick();
    mon_en = 1'b1;
    check("rst_clrn_rel", timer_clrn, 1);

    // Non-digit key and start in IDLE are ignored
    press_key(4'hA);
    check("idle_badkey_loadn", timer_loadn, 1);
    check("idle_badkey_state", state, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_start_state", state, 0);
    check("idle_start_mag", mag_on, 0);

    // Keys 3,0,0 with gaps, then a fourth key is dropped
    press_key(4'd3);
    check("k1_loadn", timer_loadn, 0);
    check("k1_data", timer_data, 3);
    check("k1_state", state, 1);
    tick();
    check("k1_gap_loadn", timer_loadn, 1);
    check("k1_gap_data", timer_data, 0);
    press_key(4'd0);
    check("k2_loadn", timer_loadn, 0);
    check("k2_data", timer_data, 0);
    tick();
    check("k2_gap_loadn", timer_loadn, 1);
    press_key(4'd0);
    check("k3_loadn", timer_loadn, 0);
    tick();
    press_key(4'd5);
    check("k4_loadn", timer_loadn, 1);
    check("k4_data", timer_data, 0);
    check("k4_state", state, 1);

    // Start refused with door open, then with timer at zero
    door_closed = 1'b0; start = 1'b1;
    tick();
    check("start_dooropen_state", state, 1);
    check("start_dooropen_mag", mag_on, 0);
    door_closed = 1'b1; timer_zero = 1'b1;
    tick();
    check("start_tz_state", state, 1);
    timer_zero = 1'b0;

    // Start cooking: strobe every 4th cycle
    tick();
    start = 1'b0;
    check("cook_state", state, 2);
    check("cook_mag", mag_on, 1);
    check("cook_en0", timer_enable, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("cook_pre_en", timer_enable, 0);
    end
    tick();
    check("cook_strobe1", timer_enable, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("cook_mid_en", timer_enable, 0);
    end
    tick();
    check("cook_strobe2", timer_enable, 1);
    tick();
    tick();  // prescaler now at 2

    // Door opens mid-cook
    door_closed = 1'b0;
    tick();
    check("pause_state", state, 3);
    check("pause_mag", mag_on, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("pause_en", timer_enable, 0);
      check("pause_hold", state, 3);
    end
    door_closed = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("resume_state", state, 2);
    check("resume_mag", mag_on, 1);
    check("resume_en", timer_enable, 0);
    tick();
    check("resume_rem_en0", timer_enable, 0);
    tick();
    check("resume_rem_strobe", timer_enable, 1);

    // Stop pauses; start+stop together in PAUSED clears to IDLE
    stop_clear = 1'b1;
    tick();
    stop_clear = 1'b0;
    check("stop_pause_state", state, 3);
    check("stop_pause_mag", mag_on, 0);
    tick();
    start = 1'b1; stop_clear = 1'b1;
    tick();
    start = 1'b0; stop_clear = 1'b0;
    check("pclr_state", state, 0);
    check("pclr_clrn", timer_clrn, 0);
    check("pclr_mag", mag_on, 0);
    tick();
    check("pclr_clrn_rel", timer_clrn, 1);
    check("pclr_mag2", mag_on, 0);

    // Cook to completion, beep for BEEP_CYCLES
    press_key(4'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("cook2_state", state, 2);
    tick();
    tick();
    timer_zero = 1'b1;
    tick();
    timer_zero = 1'b0;
    check("done_state", state, 4);
    check("done_mag", mag_on, 0);
    check("done_en", timer_enable, 0);
    check("done_beep", beep, 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("done_beep_hold", beep, 1);
      check("done_state_hold", state, 4);
    end
    tick();
    check("beep_end", beep, 0);
    check("beep_end_state", state, 0);
    press_key(4'd7);
    check("after_done_loadn", timer_loadn, 0);
    check("after_done_data", timer_data, 7);

    // Key ends DONE early without loading
    start = 1'b1;
    tick();
    start = 1'b0;
    timer_zero = 1'b1;
    tick();
    timer_zero = 1'b0;
    check("done2_state", state, 4);
    press_key(4'd2);
    check("done_key_state", state, 0);
    check("done_key_loadn", timer_loadn, 1);
    check("done_key_beep", beep, 0);

    // clr mid-cook
    press_key(4'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("cook3_mag", mag_on, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_state", state, 0);
    check("clr_mag", mag_on, 0);
    check("clr_clrn", timer_clrn, 0);
    check("clr_loadn", timer_loadn, 1);
    check("clr_en", timer_enable, 0);
    check("clr_beep", beep, 0);
    tick();
    check("clr_clrn_rel", timer_clrn, 1);

    // stop_clear in ENTRY
    press_key(4'd4);
    check("entry_state", state, 1);
    stop_clear = 1'b1;
    tick();
    stop_clear = 1'b0;
    check("entry_clr_state", state, 0);
    check("entry_clr_clrn", timer_clrn, 0);
    tick();
    check("entry_clr_rel", timer_clrn, 1);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/microwave_controller.md
MICROWAVE_CONTROLLER -- requirements
Module: microwave_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100, meaning clk cycles per one-second count strobe (min 2).
REQ-002 SHALL have parameter BEEP_CYCLES, default 300, meaning done-beep duration in clk cycles (min 1).
REQ-003 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port key_valid  input  1  one-cycle keypad strobe.
REQ-006 SHALL have port key_data  input  4  keypad digit, valid with key_valid.
REQ-007 SHALL have port start  input  1  start/resume button, level sampled each cycle.
REQ-008 SHALL have port stop_clear  input  1  stop/clear button, level sampled each cycle.
REQ-009 SHALL have port door_closed  input  1  1 = door closed.
REQ-010 SHALL have port timer_zero  input  1  timer reports 0:00.
REQ-011 SHALL have port timer_clrn  output  1  active-low clear to timer.
REQ-012 SHALL have port timer_loadn  output  1  active-low digit load to timer.
REQ-013 SHALL have port timer_data  output  4  digit presented to timer.
REQ-014 SHALL have port timer_enable  output  1  one-cycle count-down strobe to timer.
REQ-015 SHALL have port mag_on  output  1  magnetron drive.
REQ-016 SHALL have port beep  output  1  done indicator.
REQ-017 SHALL have port state  output  3  IDLE=0, ENTRY=1, COOKING=2, PAUSED=3, DONE=4.

Function
REQ-018 SHALL register all outputs; response appears the cycle after the triggering input is sampled.
REQ-019 SHALL, in IDLE or ENTRY, on key_valid with key_data<=9 and digit count<3, drive timer_loadn=0 and timer_data=key_data for exactly one cycle, increment the digit count, and enter ENTRY.
REQ-020 SHALL ignore key_valid with key_data>9, with digit count=3, or in COOKING/PAUSED/DONE (no loadn pulse).
REQ-021 SHALL keep timer_loadn=1 and timer_data=0 in every cycle without a load pulse.
REQ-022 SHALL ignore start in IDLE and DONE.
REQ-023 SHALL go ENTRY->COOKING on start when door_closed=1 and timer_zero=0; start with door open or timer_zero=1 is ignored.
REQ-024 SHALL, in COOKING, hold mag_on=1 and run a prescaler 0..TICK_DIV-1, pulsing timer_enable for one cycle on each prescaler wrap (first strobe TICK_DIV cycles after entry from ENTRY).
REQ-025 SHALL go COOKING->PAUSED when door_closed=0 or stop_clear=1: mag_on=0 next cycle, prescaler frozen, no timer_enable.
REQ-026 SHALL go PAUSED->COOKING on start with door_closed=1 and stop_clear=0, resuming the prescaler from its frozen value.
REQ-027 SHALL go PAUSED->IDLE on stop_clear while paused (a second press), pulsing timer_clrn=0 one cycle and clearing digit count and prescaler.
REQ-028 SHALL go ENTRY->IDLE on stop_clear, pulsing timer_clrn=0 one cycle and clearing digit count.
REQ-029 SHALL go COOKING->DONE when timer_zero=1 is sampled; mag_on=0 and timer_enable=0 from the next cycle.
REQ-030 SHALL, in DONE, hold beep=1 for BEEP_CYCLES cycles then enter IDLE with digit count 0; stop_clear or key_valid ends DONE early (key not loaded).
REQ-031 SHALL give priority, same cycle: stop_clear > door open > timer_zero > start > key_valid.
REQ-032 SHALL assert at most one of timer_loadn=0, timer_clrn=0, timer_enable=1 in any cycle.
REQ-033 SHALL never assert mag_on while door_closed was 0 in the previous cycle.

Reset
REQ-034 SHALL, in any cycle clr=1 is sampled, set state=IDLE, digit count=0, prescaler=0, beep counter=0, timer_clrn=0, timer_loadn=1, timer_data=0, timer_enable=0, mag_on=0, beep=0.
REQ-035 SHALL return timer_clrn to 1 the first cycle after clr deasserts; clr mid-cook stops mag_on the next cycle.

Verification
REQ-036 Keys 3,0,0 with gaps -> three single-cycle loadn pulses, timer_data 3,0,0; fourth key 5 -> no pulse; state=1.
REQ-037 After REQ-036 entry, start with door closed, TICK_DIV=4 -> mag_on=1, timer_enable every 4th cycle; timer_zero=1 -> DONE, beep high exactly BEEP_CYCLES, then state=0.
REQ-038 Door opens mid-cook -> mag_on=0 next cycle, PAUSED, no strobes; door closes + start -> resumes, next strobe at frozen prescaler remainder.
REQ-039 start and stop_clear same cycle in PAUSED -> IDLE, timer_clrn low one cycle, mag_on stays 0.
REQ-040 key_data=4'hA in IDLE -> no loadn pulse, state stays 0; start in IDLE -> ignored.
REQ-041 clr=1 during COOKING -> all outputs to REQ-034 values next cycle, timer_clrn=1 one cycle after clr drops.
